// File: rtl/memory_responder.sv
// Memory-side responder: word RAM with byte-lane masked access, programmable wait states
// and a one-cycle done pulse. Define MEMORY_ERROR_CHECK_EN to enable alignment/range faults.
module memory_responder #(
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned LATENCY   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        memory_interface_enable,
  input  logic        memory_interface_state,
  input  logic [31:0] memory_interface_address,
  input  logic [3:0]  memory_interface_frame_mask,
  input  logic [31:0] memory_interface_data_in,
  output logic [31:0] memory_interface_data_out,
  output logic        memory_interface_done,
  output logic        memory_interface_busy,
  output logic        memory_interface_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_write_q;
  logic [31:0] req_addr_q;
  logic [3:0]  req_mask_q;
  logic [31:0] req_data_q;
  logic [31:0] data_out_q;
  logic        error_q;

  logic        latch_req;
  logic        enter_done;
  logic        use_req;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [3:0]  acc_mask;
  logic [31:0] acc_data;
  logic [AW-1:0] acc_idx;
  logic [31:0] rd_word;
  logic [31:0] rd_masked;
  logic        fault;
  logic        mem_we;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_req  = 1'b0;
    enter_done = 1'b0;
    use_req    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (memory_interface_enable) begin
          latch_req = 1'b1;
          if (LATENCY == 0) begin
            state_d    = StDone;
            enter_done = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        use_req = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d    = StDone;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access completes on the accept edge, straight from the inputs.
  assign acc_write = use_req ? req_write_q : memory_interface_state;
  assign acc_addr  = use_req ? req_addr_q  : memory_interface_address;
  assign acc_mask  = use_req ? req_mask_q  : memory_interface_frame_mask;
  assign acc_data  = use_req ? req_data_q  : memory_interface_data_in;
  assign acc_idx   = acc_addr[AW+1:2];

  assign rd_word = mem[acc_idx];
  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < 4; i++) begin
      if (acc_mask[i]) rd_masked[8*i +: 8] = rd_word[8*i +: 8];
    end
  end

`ifdef MEMORY_ERROR_CHECK_EN
  localparam logic [32:0] ByteLimit = 33'(DEPTH) * 33'd4;
  assign fault = ((acc_addr[1:0] != 2'b00) && (acc_mask == 4'hF)) ||
                 ({1'b0, acc_addr} >= ByteLimit);
`else
  logic unused_addr;
  assign unused_addr = ^{acc_addr[1:0], acc_addr[31:AW+2]};
  assign fault       = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_mask_q  <= '0;
      req_data_q  <= '0;
      data_out_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        req_write_q <= memory_interface_state;
        req_addr_q  <= memory_interface_address;
        req_mask_q  <= memory_interface_frame_mask;
        req_data_q  <= memory_interface_data_in;
      end
      if (enter_done && (fault || !acc_write)) begin
        data_out_q <= fault ? 32'h0 : rd_masked;
      end
      error_q <= enter_done & fault;
    end
  end

  // Gated by reset so a request held during reset cannot write.
  assign mem_we = enter_done & acc_write & ~fault & ~reset;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
      end
    end
  end

  assign memory_interface_data_out = data_out_q;
  assign memory_interface_done     = (state_q == StDone);
  assign memory_interface_busy     = (state_q == StWait);
  assign memory_interface_error    = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances with 0, 2 and 3 wait states
// sharing request buses, each with its own enable.
module tb_memory_responder;

  logic        CLK;
  logic        reset;
  logic        st;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        en0, en2, en3;
  logic [31:0] d0, d2, d3;
  logic        dn0, dn2, dn3;
  logic        bz0, bz2, bz3;
  logic        er0, er2, er3;

  int n_chk = 0;
  int n_err = 0;
  int c;

  logic [31:0] exp5 [4] = '{32'h00000013, 32'h11111111, 32'h00BB00DD, 32'h33333333};

  memory_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .CLK(CLK), .reset(reset), .memory_interface_enable(en0), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_data_in(wdata), .memory_interface_data_out(d0),
    .memory_interface_done(dn0), .memory_interface_busy(bz0), .memory_interface_error(er0)
  );

  memory_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .CLK(CLK), .reset(reset), .memory_interface_enable(en2), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_data_in(wdata), .memory_interface_data_out(d2),
    .memory_interface_done(dn2), .memory_interface_busy(bz2), .memory_interface_error(er2)
  );

  memory_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .CLK(CLK), .reset(reset), .memory_interface_enable(en3), .memory_interface_state(st),
    .memory_interface_address(addr), .memory_interface_frame_mask(mask),
    .memory_interface_data_in(wdata), .memory_interface_data_out(d3),
    .memory_interface_done(dn3), .memory_interface_busy(bz3), .memory_interface_error(er3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return dn0;
      2:       return dn2;
      default: return dn3;
    endcase
  endfunction

  // Present one request for a single edge on the selected instance.
  task automatic issue(input int which, input logic w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    st = w; addr = a; mask = m; wdata = d;
    case (which)
      0:       en0 = 1'b1;
      2:       en2 = 1'b1;
      default: en3 = 1'b1;
    endcase
    tick();
    en0 = 1'b0; en2 = 1'b0; en3 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag, output int cycles);
    cycles = 0;
    while (!done_of(which) && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, 32'(done_of(which)), 32'd1);
  endtask

  initial begin
    reset = 1'b1; en0 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    st = 1'b0; addr = 32'h0; mask = 4'hF; wdata = 32'h0;

    // Reset held with enable asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_data", d0, 32'h0);
      check("rst_done", 32'(dn0 | dn2 | dn3), 32'd0);
      check("rst_busy", 32'(bz0 | bz2 | bz3), 32'd0);
    end
    reset = 1'b0; en0 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    tick();

    // Word 0 preload, then single-cycle read
    issue(0, 1'b1, 32'h0, 4'hF, 32'h00000013);
    wait_done(0, "wr0_done", c);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0);
    wait_done(0, "rd0_done", c);
    check("rd0_lat", 32'(c), 32'd0);
    check("rd0_data", d0, 32'h00000013);
    tick();
    check("rd0_done_low", 32'(dn0), 32'd0);
    check("rd0_hold", d0, 32'h00000013);

    // Masked write
    issue(0, 1'b1, 32'h8, 4'hF, 32'h0);
    wait_done(0, "wr8_clr_done", c);
    issue(0, 1'b1, 32'h8, 4'b0101, 32'hAABBCCDD);
    wait_done(0, "wr8_mask_done", c);
    check("wr_keeps_dout", d0, 32'h00000013);
    issue(0, 1'b0, 32'h8, 4'hF, 32'h0);
    wait_done(0, "rd8_done", c);
    check("rd8_data", d0, 32'h00BB00DD);
    issue(0, 1'b0, 32'h8, 4'b0011, 32'h0);
    wait_done(0, "rd8_lo_done", c);
    check("rd8_lo_data", d0, 32'h000000DD);
    issue(0, 1'b1, 32'h8, 4'b0000, 32'hFFFFFFFF);
    wait_done(0, "wr_nomask_done", c);
    issue(0, 1'b0, 32'h8, 4'hF, 32'h0);
    wait_done(0, "rd8_after_noop", c);
    check("rd8_noop_data", d0, 32'h00BB00DD);

    // Three wait states; a request during busy is dropped
    issue(3, 1'b1, 32'h4, 4'hF, 32'hCAFEF00D);
    wait_done(3, "l3_wr_done", c);
    check("l3_wr_lat", 32'(c), 32'd3);
    tick();
    st = 1'b0; addr = 32'h4; mask = 4'hF; en3 = 1'b1;
    tick();
    check("l3_busy0", 32'(bz3), 32'd1);
    check("l3_done0", 32'(dn3), 32'd0);
    addr = 32'h8;
    tick();
    check("l3_busy1", 32'(bz3), 32'd1);
    check("l3_done1", 32'(dn3), 32'd0);
    tick();
    check("l3_busy2", 32'(bz3), 32'd1);
    check("l3_done2", 32'(dn3), 32'd0);
    tick();
    en3 = 1'b0;
    check("l3_done3", 32'(dn3), 32'd1);
    check("l3_busy3", 32'(bz3), 32'd0);
    check("l3_data", d3, 32'hCAFEF00D);
    tick();
    check("l3_no_queue_done", 32'(dn3 | bz3), 32'd0);
    check("l3_data_hold", d3, 32'hCAFEF00D);

    // Back-to-back reads
    issue(0, 1'b1, 32'h4, 4'hF, 32'h11111111);
    wait_done(0, "wr4_done", c);
    issue(0, 1'b1, 32'hC, 4'hF, 32'h33333333);
    wait_done(0, "wr12_done", c);
    st = 1'b0; mask = 4'hF; en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      tick();
      check("b2b_done", 32'(dn0), 32'd1);
      check("b2b_data", d0, exp5[i]);
    end
    en0 = 1'b0;
    tick();
    check("b2b_end", 32'(dn0), 32'd0);

    // Reset during a pending write
    issue(2, 1'b1, 32'h4, 4'hF, 32'h0BADBEEF);
    wait_done(2, "l2_wr_done", c);
    check("l2_wr_lat", 32'(c), 32'd2);
    tick();
    issue(2, 1'b1, 32'h4, 4'hF, 32'h12345678);
    check("l2_busy", 32'(bz2), 32'd1);
    reset = 1'b1;
    #1;
    check("l2_rst_idle", 32'(dn2 | bz2), 32'd0);
    tick();
    check("l2_rst_done1", 32'(dn2), 32'd0);
    tick();
    check("l2_rst_done2", 32'(dn2), 32'd0);
    reset = 1'b0;
    tick();
    check("l2_post_done", 32'(dn2), 32'd0);
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0);
    wait_done(2, "l2_rd_done", c);
    check("l2_rd_old", d2, 32'h0BADBEEF);

`ifdef MEMORY_ERROR_CHECK_EN
    issue(0, 1'b0, 32'h2, 4'hF, 32'h0);
    wait_done(0, "misalign_done", c);
    check("misalign_err", 32'(er0), 32'd1);
    check("misalign_data", d0, 32'h0);
    tick();
    check("err_clears", 32'(er0), 32'd0);
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
    wait_done(0, "range_done", c);
    check("range_err", 32'(er0), 32'd1);
    issue(0, 1'b0, 32'h2, 4'b0011, 32'h0);
    wait_done(0, "partial_done", c);
    check("partial_err", 32'(er0), 32'd0);
    check("partial_data", d0, 32'h00000013);
`else
    issue(0, 1'b0, 32'h2, 4'hF, 32'h0);
    wait_done(0, "misalign_done", c);
    check("misalign_err", 32'(er0), 32'd0);
    check("misalign_data", d0, 32'h00000013);
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0);
    wait_done(0, "wrap_done", c);
    check("wrap_err", 32'(er0), 32'd0);
    check("wrap_data", d0, 32'h00000013);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
